// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl
// Brief    : Unsigned WIDTH x WIDTH multiplier that reuses a single 2x2
//            gate-level multiplier cell over every pair of 2-bit operand
//            digits, accumulating shifted partial products. Start/ready/done
//            handshake; product held in P until the next completion.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;

  logic [1:0]      a_dig;
  logic [1:0]      b_dig;
  logic [3:0]      pp;
  logic [CW+1:0]   shamt;
  logic [PW-1:0]   pp_ext;
  logic [PW-1:0]   pp_shift;
  logic [PW-1:0]   sum;

  // Digit selection from the registered operands by the current i/j counters.
  always_comb begin
    a_dig = 2'b00;
    b_dig = 2'b00;
    for (int d = 0; d < N; d++) begin
      if (i_q == CW'(d)) a_dig = a_q[2*d +: 2];
      if (j_q == CW'(d)) b_dig = b_q[2*d +: 2];
    end
  end

  // The single shared 2x2 multiplier cell, written out at gate level.
  always_comb begin
    logic c1;
    pp[0] = a_dig[0] & b_dig[0];
    pp[1] = (a_dig[1] & b_dig[0]) ^ (a_dig[0] & b_dig[1]);
    c1    = (a_dig[1] & b_dig[0]) & (a_dig[0] & b_dig[1]);
    pp[2] = (a_dig[1] & b_dig[1]) ^ c1;
    pp[3] = (a_dig[1] & b_dig[1]) & c1;
  end

  // Partial product weighted by 4^(i+j) and added to the running sum.
  always_comb begin
    shamt    = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    pp_ext   = {{(PW-4){1'b0}}, pp};
    pp_shift = pp_ext << shamt;
    sum      = acc_q + pp_shift;
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = sum;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            // Final digit pair: the completed sum goes straight to P.
            i_d     = '0;
            p_d     = sum;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  // Outputs are decoded from state or taken straight from registers.
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
    P     = p_q;
  end

endmodule
`default_nettype wire
